kbd_move_decoder: RTL
=====================

// Module: kbd_move_decoder
// PURPOSE
//  Keyboard-side producer of the player movement commands. Consumes PS/2 set-2 scan-code bytes from the
//  byte receiver, tracks held keys (make/break, E0-extended) and drives frame-aligned, active-low
//  moveLeft/moveRight levels plus a one-cycle fire pulse. Sits between the PS/2 byte receiver and the
//  player move/collision block; its outputs change only on startOfFrame.
// PARAMETERS
//  LEFT_CODE      8'h1C  scan code, left key ('A')
//  RIGHT_CODE     8'h23  scan code, right key ('D')
//  FIRE_CODE      8'h29  scan code, fire key (space)
//  ARROW_L_CODE   8'h6B  E0-prefixed left arrow (used only with KBD_ARROW_KEYS_EN)
//  ARROW_R_CODE   8'h74  E0-prefixed right arrow (used only with KBD_ARROW_KEYS_EN)
// PORTS
//  clk           in   1  system clock
//  resetN        in   1  asynchronous active-low reset
//  startOfFrame  in   1  one-clk pulse per video frame
//  byteValid     in   1  one-clk strobe, byteData is valid
//  byteData      in   8  received scan-code byte
//  moveLeft      out  1  active-low, left held (frame-aligned)
//  moveRight     out  1  active-low, right held (frame-aligned)
//  firePulse     out  1  one-clk high pulse on startOfFrame after a fresh fire press
// BEHAVIOUR
//  - Reset (async, resetN=0): moveLeft=1, moveRight=1, firePulse=0, FSM=IDLE, held flags/lastDir/firePending=0.
//  - Prefix FSM, advances only on byteValid: IDLE -E0-> EXT; IDLE -F0-> BRK; EXT -F0-> EXT_BRK;
//    BRK -E0-> EXT_BRK (tolerant order). Any other byte: decode with ext=(EXT|EXT_BRK),
//    brk=(BRK|EXT_BRK), then -> IDLE. E0 in EXT/EXT_BRK or F0 in BRK/EXT_BRK: stay.
//  - In IDLE, 8'hAA (BAT) and 8'hFA (ACK) are discarded; unknown codes discarded; FSM -> IDLE.
//  - Decode: non-ext LEFT/RIGHT/FIRE set (make) or clear (break) leftHeld/rightHeld/fireHeld.
//    Make of LEFT sets lastDir=0, RIGHT sets lastDir=1; typematic repeats re-assert harmlessly.
//  - Fire: make of FIRE while fireHeld==0 sets firePending; repeats while held are ignored.
//  - On startOfFrame (using register values before this edge): moveLeft=~(leftHeld&(~rightHeld|lastDir==0)),
//    moveRight=~(rightHeld&(~leftHeld|lastDir==1)) -> never both low; firePulse=firePending,
//    firePending cleared. firePulse is 0 in every other cycle.
//  - byteValid coincident with startOfFrame: byte updates state this edge, outputs reflect it next frame.
//  - Latency: key event -> output change at the first startOfFrame strictly after the byteValid cycle.
//  - Reset mid-sequence (e.g., after E0): prefix lost, next byte decoded from IDLE.
// CONFIGURATION
//  KBD_ARROW_KEYS_EN defined: ext ARROW_L_CODE/ARROW_R_CODE act exactly as LEFT/RIGHT (OR-ed into the
//    same held flags, both sources tracked separately so releasing one keeps the other held).
//  Undefined: E0 prefixes still tracked by FSM, extended codes consumed with no effect.
// STRUCTURE
//  Package kbd_pkg: scan-code constants (E0, F0, AA, FA, default key codes), prefix-state enum
//    {IDLE, EXT, BRK, EXT_BRK}.
//  Sub-module kbd_prefix_fsm: byte -> {codeValid, code, ext, brk} strobe; top holds key/frame logic.
// TESTING
//  1 Reset: outputs moveLeft=1, moveRight=1, firePulse=0 held through 3 frames with no bytes.
//  2 Bytes 1C, then SOF -> moveLeft=0; bytes F0,1C, then SOF -> moveLeft=1; no change before SOF.
//  3 1C then 23 (both held), SOF -> moveRight=0, moveLeft=1; F0,23, SOF -> moveLeft=0 (left still held).
//  4 29,29,29 (repeat) within one frame -> exactly one firePulse at next SOF; none at following SOF.
//  5 E0,6B then SOF: with KBD_ARROW_KEYS_EN moveLeft=0; without it moveLeft=1 and FSM back in IDLE
//    (following 1C acts as plain make).
//  6 E0 then resetN pulse then 1C, SOF -> moveLeft=0; byteValid(1C) same cycle as SOF -> change next SOF.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared scan-code constants and prefix-state encoding for the keyboard move decoder.
package kbd_pkg;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;
   localparam logic [7:0] SC_BAT = 8'hAA;
   localparam logic [7:0] SC_ACK = 8'hFA;

   localparam logic [7:0] DEF_LEFT_CODE    = 8'h1C;
   localparam logic [7:0] DEF_RIGHT_CODE   = 8'h23;
   localparam logic [7:0] DEF_FIRE_CODE    = 8'h29;
   localparam logic [7:0] DEF_ARROW_L_CODE = 8'h6B;
   localparam logic [7:0] DEF_ARROW_R_CODE = 8'h74;

   typedef enum logic [1:0] {
      PFX_IDLE,
      PFX_EXT,
      PFX_BRK,
      PFX_EXT_BRK
   } pfx_state_e;

endpackage

// File: rtl/kbd_prefix_fsm.sv
// PS/2 set-2 prefix tracker: folds E0/F0 prefixes into a {code, ext, brk} strobe.
module kbd_prefix_fsm
   import kbd_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       byte_valid_i,
   input  logic [7:0] byte_i,
   output logic       code_valid_o,
   output logic [7:0] code_o,
   output logic       ext_o,
   output logic       brk_o
);

   pfx_state_e state_q, state_d;

   // Strobe is combinational so a byte can update key state on the same edge it arrives.
   always_comb begin
      state_d      = state_q;
      code_valid_o = 1'b0;
      code_o       = byte_i;
      ext_o        = (state_q == PFX_EXT) || (state_q == PFX_EXT_BRK);
      brk_o        = (state_q == PFX_BRK) || (state_q == PFX_EXT_BRK);
      if (byte_valid_i) begin
         if (byte_i == SC_EXT) begin
            state_d = brk_o ? PFX_EXT_BRK : PFX_EXT;
         end else if (byte_i == SC_BRK) begin
            state_d = ext_o ? PFX_EXT_BRK : PFX_BRK;
         end else begin
            state_d      = PFX_IDLE;
            code_valid_o = !((state_q == PFX_IDLE) && ((byte_i == SC_BAT) || (byte_i == SC_ACK)));
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= PFX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/kbd_move_decoder.sv
// Held-key tracking and frame-aligned move/fire outputs from PS/2 scan codes.
// Optional feature: define KBD_ARROW_KEYS_EN to make E0-extended arrows act as left/right.
module kbd_move_decoder
   import kbd_pkg::*;
#(
   parameter logic [7:0] LEFT_CODE    = DEF_LEFT_CODE,
   parameter logic [7:0] RIGHT_CODE   = DEF_RIGHT_CODE,
`ifdef KBD_ARROW_KEYS_EN
   parameter logic [7:0] ARROW_L_CODE = DEF_ARROW_L_CODE,
   parameter logic [7:0] ARROW_R_CODE = DEF_ARROW_R_CODE,
`endif
   parameter logic [7:0] FIRE_CODE    = DEF_FIRE_CODE
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       byteValid,
   input  logic [7:0] byteData,
   output logic       moveLeft,
   output logic       moveRight,
   output logic       firePulse
);

   logic       code_valid, ext, brk;
   logic [7:0] code;

   kbd_prefix_fsm u_prefix (
      .clk_i        (clk),
      .rst_ni       (resetN),
      .byte_valid_i (byteValid),
      .byte_i       (byteData),
      .code_valid_o (code_valid),
      .code_o       (code),
      .ext_o        (ext),
      .brk_o        (brk)
   );

   logic left_held_q, left_held_d, right_held_q, right_held_d;
   logic fire_held_q, fire_held_d, last_dir_q, last_dir_d;
   logic fire_pending_q, fire_pending_d;
   logic move_left_q, move_left_d, move_right_q, move_right_d;
   logic fire_pulse_q, fire_pulse_d;
   logic left_any, right_any;

`ifdef KBD_ARROW_KEYS_EN
   logic arrow_l_q, arrow_l_d, arrow_r_q, arrow_r_d;
   assign left_any  = left_held_q | arrow_l_q;
   assign right_any = right_held_q | arrow_r_q;
`else
   assign left_any  = left_held_q;
   assign right_any = right_held_q;
`endif

   always_comb begin
      left_held_d    = left_held_q;
      right_held_d   = right_held_q;
      fire_held_d    = fire_held_q;
      last_dir_d     = last_dir_q;
      fire_pending_d = fire_pending_q;
      move_left_d    = move_left_q;
      move_right_d   = move_right_q;
      fire_pulse_d   = 1'b0;
`ifdef KBD_ARROW_KEYS_EN
      arrow_l_d      = arrow_l_q;
      arrow_r_d      = arrow_r_q;
`endif
      if (startOfFrame) begin
         move_left_d    = ~(left_any & (~right_any | ~last_dir_q));
         move_right_d   = ~(right_any & (~left_any | last_dir_q));
         fire_pulse_d   = fire_pending_q;
         fire_pending_d = 1'b0;
      end
      // A fire make on the SOF edge survives the clear above and pulses next frame.
      if (code_valid && !ext) begin
         if (code == LEFT_CODE) begin
            left_held_d = ~brk;
            if (!brk) last_dir_d = 1'b0;
         end else if (code == RIGHT_CODE) begin
            right_held_d = ~brk;
            if (!brk) last_dir_d = 1'b1;
         end else if (code == FIRE_CODE) begin
            if (!brk && !fire_held_q) fire_pending_d = 1'b1;
            fire_held_d = ~brk;
         end
      end
`ifdef KBD_ARROW_KEYS_EN
      if (code_valid && ext) begin
         if (code == ARROW_L_CODE) begin
            arrow_l_d = ~brk;
            if (!brk) last_dir_d = 1'b0;
         end else if (code == ARROW_R_CODE) begin
            arrow_r_d = ~brk;
            if (!brk) last_dir_d = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         left_held_q    <= 1'b0;
         right_held_q   <= 1'b0;
         fire_held_q    <= 1'b0;
         last_dir_q     <= 1'b0;
         fire_pending_q <= 1'b0;
         move_left_q    <= 1'b1;
         move_right_q   <= 1'b1;
         fire_pulse_q   <= 1'b0;
`ifdef KBD_ARROW_KEYS_EN
         arrow_l_q      <= 1'b0;
         arrow_r_q      <= 1'b0;
`endif
      end else begin
         left_held_q    <= left_held_d;
         right_held_q   <= right_held_d;
         fire_held_q    <= fire_held_d;
         last_dir_q     <= last_dir_d;
         fire_pending_q <= fire_pending_d;
         move_left_q    <= move_left_d;
         move_right_q   <= move_right_d;
         fire_pulse_q   <= fire_pulse_d;
`ifdef KBD_ARROW_KEYS_EN
         arrow_l_q      <= arrow_l_d;
         arrow_r_q      <= arrow_r_d;
`endif
      end
   end

   assign moveLeft  = move_left_q;
   assign moveRight = move_right_q;
   assign firePulse = fire_pulse_q;

endmodule
